ppi_strobe_port: RTL and testbench

- Clocked Mode 1 strobed-handshake engine for one 8-bit port of the programmable peripheral interface.
- Sits between the port-side pins and the CPU-side port latch/read mux.
- Synchronises peripheral strobes (STB#/ACK#) and generates IBF, OBF# and INTR.
- Holds input and output data latches plus the INTE flag; one instance serves Port A and one serves Port B.

---
 rtl/ppi_strobe_port.sv | 143 ++++++++++++++
 tb/tb_ppi_strobe_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ppi_strobe_port.sv
// Mode 1 strobed-handshake engine for one PPI port: synchronises STB#/ACK#, latches data, drives IBF/OBF#/INTR.
// Pin events act 3 edges after the pin changes (SYNC_STAGES=2); CPU strobes act on the next edge; no backpressure.
module ppi_strobe_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_enable,
    input  logic             cfg_dir,
    input  logic             inte_set,
    input  logic             inte_clr,
    input  logic             cpu_wr_stb,
    input  logic [WIDTH-1:0] cpu_wr_data,
    input  logic             cpu_rd_stb,
    output logic [WIDTH-1:0] cpu_rd_data,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             overrun
);
    localparam int LAST = SYNC_STAGES - 1;

    typedef enum logic {EMPTY, FULL} in_state_t;
    typedef enum logic [1:0] {IDLE, PEND, DONE} out_state_t;

    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [WIDTH-1:0]       data_sync [SYNC_STAGES];
    logic                   stb_dly;
    logic                   ack_dly;
    logic                   dir_q;
    logic                   inte;
    in_state_t              in_state;
    out_state_t             out_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_sync <= '1;
            ack_sync <= '1;
            stb_dly  <= 1'b1;
            ack_dly  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            stb_sync     <= {stb_sync[SYNC_STAGES-2:0], stb_n};
            ack_sync     <= {ack_sync[SYNC_STAGES-2:0], ack_n};
            stb_dly      <= stb_sync[LAST];
            ack_dly      <= ack_sync[LAST];
            data_sync[0] <= port_in;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    // Data is taken from the same sync stage as the strobe so a capture sees matching bits.
    logic stb_fall, stb_rise, ack_fall, ack_rise, clr;
    assign stb_fall = stb_dly & ~stb_sync[LAST];
    assign stb_rise = ~stb_dly & stb_sync[LAST];
    assign ack_fall = ack_dly & ~ack_sync[LAST];
    assign ack_rise = ~ack_dly & ack_sync[LAST];
    assign clr      = ~cfg_enable | (cfg_dir != dir_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q       <= cfg_dir;
            inte        <= 1'b0;
            ibf         <= 1'b0;
            obf_n       <= 1'b1;
            intr        <= 1'b0;
            overrun     <= 1'b0;
            port_out    <= '0;
            cpu_rd_data <= '0;
            port_oe     <= 1'b0;
            in_state    <= EMPTY;
            out_state   <= IDLE;
        end else begin
            dir_q <= cfg_dir;
            if (inte_clr)
                inte <= 1'b0;
            else if (inte_set)
                inte <= 1'b1;

            if (clr) begin
                ibf         <= 1'b0;
                obf_n       <= 1'b1;
                intr        <= 1'b0;
                overrun     <= 1'b0;
                port_out    <= '0;
                cpu_rd_data <= '0;
                port_oe     <= 1'b0;
                in_state    <= EMPTY;
                out_state   <= IDLE;
            end else begin
                port_oe <= ~cfg_dir;
                if (cfg_dir) begin
                    // A capture coinciding with a read counts as fresh data, not an overrun.
                    if (stb_fall) begin
                        cpu_rd_data <= data_sync[LAST];
                        ibf         <= 1'b1;
                        in_state    <= FULL;
                        if (cpu_rd_stb) begin
                            intr    <= 1'b0;
                            overrun <= 1'b0;
                        end else if (in_state == FULL) begin
                            overrun <= 1'b1;
                        end
                    end else if (cpu_rd_stb) begin
                        ibf      <= 1'b0;
                        intr     <= 1'b0;
                        overrun  <= 1'b0;
                        in_state <= EMPTY;
                    end else if (stb_rise && ibf && inte) begin
                        intr <= 1'b1;
                    end
                end else begin
                    if (cpu_wr_stb) begin
                        port_out  <= cpu_wr_data;
                        obf_n     <= 1'b0;
                        intr      <= 1'b0;
                        out_state <= PEND;
                    end else begin
                        case (out_state)
                            PEND: if (ack_fall) begin
                                obf_n     <= 1'b1;
                                out_state <= DONE;
                            end
                            DONE: if (ack_rise) begin
                                intr      <= inte;
                                out_state <= IDLE;
                            end
                            default: out_state <= IDLE;
                        endcase
                    end
                end
                if (inte_clr) intr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ppi_strobe_port.sv
// Scenario bench for ppi_strobe_port: captured and written bytes are scoreboarded through queues.
module tb_ppi_strobe_port;
    logic       clk = 1'b0;
    logic       reset, cfg_enable, cfg_dir, inte_set, inte_clr;
    logic       cpu_wr_stb, cpu_rd_stb, stb_n, ack_n;
    logic [7:0] cpu_wr_data, port_in;
    logic [7:0] cpu_rd_data, port_out;
    logic       port_oe, ibf, obf_n, intr, overrun;

    int passed = 0;
    int total  = 0;
    logic [7:0] rd_q [$];
    logic [7:0] wr_q [$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    ppi_strobe_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_dir(cfg_dir),
        .inte_set(inte_set), .inte_clr(inte_clr),
        .cpu_wr_stb(cpu_wr_stb), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_stb(cpu_rd_stb), .cpu_rd_data(cpu_rd_data),
        .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
        .stb_n(stb_n), .ack_n(ack_n),
        .ibf(ibf), .obf_n(obf_n), .intr(intr), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        cpu_rd_stb = 1'b1; tick(); cpu_rd_stb = 1'b0;
    endtask

    task automatic pulse_inte_set();
        inte_set = 1'b1; tick(); inte_set = 1'b0;
    endtask

    task automatic strobe_in(input logic [7:0] d, input int lowc);
        port_in = d;
        rd_q.push_back(d);
        stb_n = 1'b0;
        repeat (lowc) tick();
        stb_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_capture(input string name);
        int n = 0;
        while (ibf !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (ibf !== 1'b1) $display("FAIL %s_ibf_timeout got=%b exp=1", name, ibf); else passed++;
        exp_b = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
        total++; if (cpu_rd_data !== exp_b) $display("FAIL %s_data got=%h exp=%h", name, cpu_rd_data, exp_b); else passed++;
    endtask

    task automatic cpu_write(input logic [7:0] d, input string name);
        cpu_wr_data = d;
        wr_q.push_back(d);
        cpu_wr_stb = 1'b1; tick(); cpu_wr_stb = 1'b0;
        exp_b = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
        total++; if (port_out !== exp_b) $display("FAIL %s_port_out got=%h exp=%h", name, port_out, exp_b); else passed++;
        total++; if (obf_n !== 1'b0) $display("FAIL %s_obf_n got=%b exp=0", name, obf_n); else passed++;
    endtask

    task automatic ack_pulse();
        ack_n = 1'b0; repeat (3) tick();
        ack_n = 1'b1; repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_enable = 1'b0; cfg_dir = 1'b1; inte_set = 1'b0; inte_clr = 1'b0;
        cpu_wr_stb = 1'b0; cpu_rd_stb = 1'b0; cpu_wr_data = 8'h00; port_in = 8'h00;
        stb_n = 1'b1; ack_n = 1'b1;
        repeat (2) tick();
        total++; if ({ibf, obf_n, intr, overrun, port_oe} !== 5'b01000)
            $display("FAIL reset_flags got=%b exp=01000", {ibf, obf_n, intr, overrun, port_oe}); else passed++;
        total++; if ({port_out, cpu_rd_data} !== 16'h0000)
            $display("FAIL reset_data got=%h exp=0000", {port_out, cpu_rd_data}); else passed++;
        reset = 1'b0; cfg_enable = 1'b1;
        repeat (2) tick();
        total++; if (port_oe !== 1'b0) $display("FAIL input_port_oe got=%b exp=0", port_oe); else passed++;
    endtask

    task automatic test_input_basic();
        pulse_inte_set();
        port_in = 8'hA5; rd_q.push_back(8'hA5); stb_n = 1'b0;
        repeat (2) tick();
        total++; if (ibf !== 1'b0) $display("FAIL ibf_early got=%b exp=0", ibf); else passed++;
        tick();
        total++; if (ibf !== 1'b1) $display("FAIL ibf_latency got=%b exp=1", ibf); else passed++;
        exp_b = rd_q.pop_front();
        total++; if (cpu_rd_data !== exp_b) $display("FAIL basic_data got=%h exp=%h", cpu_rd_data, exp_b); else passed++;
        tick();
        stb_n = 1'b1;
        repeat (2) tick();
        total++; if (intr !== 1'b0) $display("FAIL intr_early got=%b exp=0", intr); else passed++;
        tick();
        total++; if (intr !== 1'b1) $display("FAIL intr_latency got=%b exp=1", intr); else passed++;
        pulse_rd();
        total++; if ({ibf, intr} !== 2'b00) $display("FAIL read_clear got=%b exp=00", {ibf, intr}); else passed++;
        total++; if (cpu_rd_data !== 8'hA5) $display("FAIL read_hold got=%h exp=a5", cpu_rd_data); else passed++;
    endtask

    task automatic test_overrun();
        strobe_in(8'h11, 3); wait_capture("ovr_first");
        total++; if (overrun !== 1'b0) $display("FAIL ovr_not_yet got=%b exp=0", overrun); else passed++;
        strobe_in(8'h22, 3); wait_capture("ovr_second");
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else passed++;
        pulse_rd();
        total++; if ({overrun, ibf} !== 2'b00) $display("FAIL ovr_clear got=%b exp=00", {overrun, ibf}); else passed++;
    endtask

    task automatic test_rd_collision();
        strobe_in(8'h55, 3); wait_capture("coll_pre");
        port_in = 8'h7E; rd_q.push_back(8'h7E); stb_n = 1'b0;
        repeat (2) tick();
        cpu_rd_stb = 1'b1; tick(); cpu_rd_stb = 1'b0;
        wait_capture("coll");
        total++; if ({overrun, intr} !== 2'b00) $display("FAIL coll_flags got=%b exp=00", {overrun, intr}); else passed++;
        stb_n = 1'b1; repeat (4) tick();
        total++; if (intr !== 1'b1) $display("FAIL coll_rise_intr got=%b exp=1", intr); else passed++;
        pulse_rd();
    endtask

    task automatic test_output();
        cfg_dir = 1'b0;
        repeat (2) tick();
        total++; if (port_oe !== 1'b1) $display("FAIL output_port_oe got=%b exp=1", port_oe); else passed++;
        cpu_write(8'h3C, "out_first");
        ack_n = 1'b0;
        repeat (2) tick();
        total++; if (obf_n !== 1'b0) $display("FAIL obf_early got=%b exp=0", obf_n); else passed++;
        tick();
        total++; if (obf_n !== 1'b1) $display("FAIL obf_latency got=%b exp=1", obf_n); else passed++;
        ack_n = 1'b1;
        repeat (2) tick();
        total++; if (intr !== 1'b0) $display("FAIL out_intr_early got=%b exp=0", intr); else passed++;
        tick();
        total++; if (intr !== 1'b1) $display("FAIL out_intr_latency got=%b exp=1", intr); else passed++;
        cpu_write(8'h5A, "out_second");
        total++; if (intr !== 1'b0) $display("FAIL wr_clears_intr got=%b exp=0", intr); else passed++;
    endtask

    task automatic test_inte_noint();
        inte_set = 1'b1; inte_clr = 1'b1; tick(); inte_set = 1'b0; inte_clr = 1'b0;
        ack_pulse();
        total++; if ({obf_n, intr} !== 2'b10) $display("FAIL noint_done got=%b exp=10", {obf_n, intr}); else passed++;
    endtask

    task automatic test_back_to_back();
        cpu_write(8'h66, "b2b_first");
        cpu_write(8'h77, "b2b_second");
    endtask

    task automatic test_reset_mid();
        pulse_inte_set();
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if ({obf_n, intr, port_oe} !== 3'b100) $display("FAIL mid_reset_flags got=%b exp=100", {obf_n, intr, port_oe}); else passed++;
        total++; if (port_out !== 8'h00) $display("FAIL mid_reset_port_out got=%h exp=00", port_out); else passed++;
    endtask

    task automatic test_dir_toggle();
        cfg_dir = 1'b1; tick();
        pulse_inte_set();
        strobe_in(8'h99, 3); wait_capture("tog_pre");
        cfg_dir = 1'b0; tick();
        total++; if ({ibf, intr} !== 2'b00) $display("FAIL tog_clear got=%b exp=00", {ibf, intr}); else passed++;
        cfg_dir = 1'b1; tick();
        strobe_in(8'hC3, 3); wait_capture("tog_post");
        total++; if (intr !== 1'b1) $display("FAIL tog_inte_kept got=%b exp=1", intr); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_input_basic();
        test_overrun();
        test_rd_collision();
        test_output();
        test_inte_noint();
        test_back_to_back();
        test_reset_mid();
        test_dir_toggle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
